// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO responder: FSM encoding, IO base and
// register offsets, plus the IO region decode helper.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mio_state_e;

  localparam logic [3:0]  IO_BASE     = 4'hF;
  localparam logic [27:0] OFF_SW_GPIO = 28'h000_0000;
  localparam logic [27:0] OFF_TIMER   = 28'h000_0004;

  function automatic logic is_io_addr(input logic [3:0] hi_nibble);
    return hi_nibble == IO_BASE;
  endfunction

endpackage

// File: rtl/mio_io_regs.sv
// IO register block: GPIO output, switch readback and the optional free-running
// timer (present only when MIO_TIMER_EN is defined).
module mio_io_regs
  import mio_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [25:0] woff_i,
  input  logic [31:0] wdata_i,
  input  logic [15:0] sw_i,
  output logic [15:0] gpio_o,
  output logic [31:0] rdata_o
);

  logic        sel_gpio;
  logic [15:0] gpio_q;

  assign sel_gpio = (woff_i == OFF_SW_GPIO[27:2]);
  assign gpio_o   = gpio_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gpio_q <= '0;
    end else if (wr_en_i && sel_gpio) begin
      gpio_q <= wdata_i[15:0];
    end
  end

`ifdef MIO_TIMER_EN
  logic        sel_timer;
  logic [31:0] timer_q, timer_d;

  assign sel_timer = (woff_i == OFF_TIMER[27:2]);

  // A software load overrides the increment in the same cycle.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (wr_en_i && sel_timer) begin
      timer_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (sel_gpio) begin
      rdata_o = {16'h0000, sw_i};
    end else if (sel_timer) begin
      rdata_o = timer_q;
    end
  end
`else
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^wdata_i[31:16];

  always_comb begin
    rdata_o = '0;
    if (sel_gpio) begin
      rdata_o = {16'h0000, sw_i};
    end
  end
`endif

endmodule

// File: rtl/mio_responder.sv
// CPU memory/IO responder: wait-state FSM with RAM path; IO registers live in
// mio_io_regs. Optional timer enabled with MIO_TIMER_EN.
module mio_responder
  import mio_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int RAM_AW      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw,
  output logic [15:0]       gpio
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  mio_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        wr_q, ready_q, we_q;
  logic        is_io, io_wr_en;
  logic [31:0] io_rdata;
  logic        unused_addr_lo;

  assign is_io          = is_io_addr(addr_q[31:28]);
  assign io_wr_en       = (state_q == ACK) && wr_q && is_io;
  assign unused_addr_lo = ^addr_q[1:0];

  assign cpu_rdata = rdata_q;
  assign MIO_ready = ready_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q[RAM_AW+1:2];
  assign ram_wdata = wdata_q;

  // Strobes are registered on the WAIT->ACK edge so they are high exactly
  // for the ACK cycle; read data is captured on that same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MemRead || MemWrite) begin
            addr_q  <= addr;
            wdata_q <= cpu_wdata;
            wr_q    <= MemWrite;
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ACK;
            ready_q <= 1'b1;
            we_q    <= wr_q && !is_io;
            if (!wr_q) begin
              rdata_q <= is_io ? io_rdata : ram_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  mio_io_regs u_io (
    .clk_i   (clk),
    .rst_i   (reset),
    .wr_en_i (io_wr_en),
    .woff_i  (addr_q[27:2]),
    .wdata_i (wdata_q),
    .sw_i    (sw),
    .gpio_o  (gpio),
    .rdata_o (io_rdata)
  );

endmodule

// File: tb/tb_mio_responder.sv
// Directed bench for mio_responder: one-wait-state instance for the main paths,
// three-wait-state instance for latency, drop-mid-wait and reset-abort cases.
module tb_mio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] addr, cpu_wdata, ram_rdata;
  logic [15:0] sw;

  logic [31:0] rd1, wd1, rd3, wd3;
  logic        rdy1, we1, rdy3, we3;
  logic [9:0]  ra1, ra3;
  logic [15:0] gp1, gp3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mio_responder #(.WAIT_CYCLES(1), .RAM_AW(10)) u1 (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rd1), .MIO_ready(rdy1),
    .ram_addr(ra1), .ram_we(we1), .ram_wdata(wd1), .ram_rdata(ram_rdata),
    .sw(sw), .gpio(gp1)
  );

  mio_responder #(.WAIT_CYCLES(3), .RAM_AW(10)) u3 (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rd3), .MIO_ready(rdy3),
    .ram_addr(ra3), .ram_we(we3), .ram_wdata(wd3), .ram_rdata(ram_rdata),
    .sw(sw), .gpio(gp3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction on the single-wait instance; returns in its ACK cycle.
  task automatic txn1(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output int lat);
    @(posedge clk); #1;
    addr = a; cpu_wdata = d; MemWrite = wr; MemRead = !wr; lat = 0;
    while (rdy1 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    int lat, n_rdy, n_we, first_we;
    logic [31:0] exp_t0, exp_t1;

    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    addr = 32'hFFFF_FFFC; cpu_wdata = 32'hFFFF_FFFF; ram_rdata = '0; sw = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_addr", 32'(ra1), 32'h0);
    chk("rst_ram_wdata", wd1, 32'h0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_ready", 32'(rdy1), 32'h0);
    chk("rst_we", 32'(we1), 32'h0);
    chk("rst_rdata", rd1, 32'h0);
    chk("rst_gpio", 32'(gp1), 32'h0);

    // RAM read, one wait state
    ram_rdata = 32'h1234_5678;
    txn1(1'b0, 32'h0000_0010, 32'h0, lat);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_ram_addr", 32'(ra1), 32'd4);
    chk("rd_data", rd1, 32'h1234_5678);
    chk("rd_no_we", 32'(we1), 32'h0);

    // RAM write leaves cpu_rdata alone
    txn1(1'b1, 32'h0000_0020, 32'hCAFE_F00D, lat);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_we", 32'(we1), 32'h1);
    chk("wr_ram_addr", 32'(ra1), 32'd8);
    chk("wr_ram_wdata", wd1, 32'hCAFE_F00D);
    chk("wr_rdata_held", rd1, 32'h1234_5678);
    @(posedge clk); #1;
    chk("wr_we_one_cycle", 32'(we1), 32'h0);
    chk("wr_ready_one_cycle", 32'(rdy1), 32'h0);

    // GPIO write and switch readback
    txn1(1'b1, 32'hF000_0000, 32'h0001_A5A5, lat);
    chk("gpio_wr_no_ram_we", 32'(we1), 32'h0);
    @(posedge clk); #1;
    chk("gpio_value", 32'(gp1), 32'h0000_A5A5);
    sw = 16'h00FF;
    txn1(1'b0, 32'hF000_0003, 32'h0, lat);
    chk("sw_read", rd1, 32'h0000_00FF);
    txn1(1'b0, 32'hF000_0010, 32'h0, lat);
    chk("io_unmapped_read", rd1, 32'h0);

    // Timer load then two back-to-back reads
`ifdef MIO_TIMER_EN
    exp_t0 = 32'hFFFF_FFFF; exp_t1 = 32'h0000_0002;
`else
    exp_t0 = 32'h0; exp_t1 = 32'h0;
`endif
    txn1(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, lat);
    txn1(1'b0, 32'hF000_0004, 32'h0, lat);
    chk("timer_rd0", rd1, exp_t0);
    chk("timer_wr_gpio_kept", 32'(gp1), 32'h0000_A5A5);
    txn1(1'b0, 32'hF000_0004, 32'h0, lat);
    chk("timer_rd1_wrapped", rd1, exp_t1);

    // Three wait states: write strobe lands at request+4
    pulse_reset();
    @(posedge clk); #1;
    addr = 32'h0000_0008; cpu_wdata = 32'hDEAD_BEEF; MemWrite = 1'b1;
    n_rdy = 0; n_we = 0; first_we = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (we3 === 1'b1) begin
        n_we++;
        if (first_we == 0) begin
          first_we = k;
          chk("w3_ram_addr", 32'(ra3), 32'd2);
          chk("w3_ram_wdata", wd3, 32'hDEAD_BEEF);
          chk("w3_ready_same_cycle", 32'(rdy3), 32'h1);
        end
      end
      if (rdy3 === 1'b1) begin
        n_rdy++;
        MemWrite = 1'b0;
      end
    end
    chk("w3_we_cycle", 32'(first_we), 32'd4);
    chk("w3_we_count", 32'(n_we), 32'd1);
    chk("w3_ready_count", 32'(n_rdy), 32'd1);

    // Both requests set, dropped mid-WAIT: one write still completes
    addr = 32'h0000_0030; cpu_wdata = 32'h0000_55AA;
    MemRead = 1'b1; MemWrite = 1'b1;
    n_rdy = 0; n_we = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        MemRead = 1'b0; MemWrite = 1'b0;
      end
      if (rdy3 === 1'b1) n_rdy++;
      if (we3 === 1'b1) n_we++;
    end
    chk("drop_ready_count", 32'(n_rdy), 32'd1);
    chk("both_is_write", 32'(n_we), 32'd1);

    // Reset during WAIT of a write aborts it
    addr = 32'h0000_0040; cpu_wdata = 32'h0000_0001; MemWrite = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_state", 32'(u3.state_q), 32'd0);
    chk("abort_ready", 32'(rdy3), 32'h0);
    chk("abort_we", 32'(we3), 32'h0);
    chk("abort_ram_addr", 32'(ra3), 32'h0);
    MemWrite = 1'b0;
    @(posedge clk); @(negedge clk); reset = 1'b0;
    n_rdy = 0; n_we = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (rdy3 === 1'b1) n_rdy++;
      if (we3 === 1'b1) n_we++;
    end
    chk("abort_no_we_after", 32'(n_we), 32'd0);
    chk("abort_no_ready_after", 32'(n_rdy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
